// File: rtl/serial_compare_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_compare_ctrl_if : request/operand/result bundle for the comparator
// Revision: 1.0
// ---------------------------------------------------------------------------
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CNT_W-1:0] cycles;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt, cycles
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt, cycles
  );
endinterface
`default_nettype wire

// File: rtl/serial_compare_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_compare_ctrl : bit-serial MSB-first magnitude comparator sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  parameter int CNT_W      = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  serial_compare_ctrl_if.slave    bus
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] C_EQUAL = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         c_q, c_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;

  logic               bit_x;
  logic               bit_y;
  logic [1:0]         c_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               finish;

  always_comb begin
    bit_x     = a_q[idx_q];
    bit_y     = b_q[idx_q];
    c_next[1] = c_q[1] | (~c_q[1] & c_q[0] & bit_x & ~bit_y);
    c_next[0] = ~c_q[1] & c_q[0] & ~(bit_x ^ bit_y);
    cnt_inc   = cnt_q + CNT_W'(1);
    finish    = (idx_q == '0) || ((EARLY_EXIT != 0) && (c_next != C_EQUAL));

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    cycles_d = cycles_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = C_EQUAL;
          idx_d   = IDX_W'(WIDTH - 1);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        c_d   = c_next;
        cnt_d = cnt_inc;
        idx_d = idx_q - IDX_W'(1);
        // Results are registered on the edge entering DONE so they are
        // valid in the same cycle as the done pulse.
        if (finish) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          gt_d     = c_next[1];
          eq_d     = ~c_next[1] & c_next[0];
          lt_d     = ~c_next[1] & ~c_next[0];
          cycles_d = cnt_inc;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.gt     = gt_q;
  assign bus.eq     = eq_q;
  assign bus.lt     = lt_q;
  assign bus.cycles = cycles_q;

endmodule
`default_nettype wire
